// File: rtl/bike_pkg.sv
// Shared types for the rider assist-level front end.
package bike_pkg;
    typedef logic [2:0] level_t;
    localparam level_t MAX_LEVEL = 3'd7;
    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DN, BRAKE} assist_state_t;
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw input.
module btn_debounce #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Count only while the synced value disagrees with the output; agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
            deb  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/assist_level_ctrl.sv
// Rider input front end: debounced up/down/brake set a target level, psw ramps
// toward it one step per ramp interval; brake forces everything to zero.
module assist_level_ctrl
    import bike_pkg::*;
#(
    parameter int LEVEL_W     = 3,
    parameter int DEB_CYCLES  = 500_000,
    parameter int RAMP_CYCLES = 5_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               brake,
    output logic [LEVEL_W-1:0] psw,
    output logic [LEVEL_W-1:0] target,
    output logic               ramping,
    output logic               braked
);
    localparam int TW = $clog2(RAMP_CYCLES + 1);
    localparam logic [TW-1:0]      TMR_LAST = TW'(RAMP_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] MAXL     = '1;

    // Bit 0 = up, 1 = down, 2 = brake.
    logic [2:0] raw_in, deb, deb_q;
    assign raw_in = {brake, btn_down, btn_up};

    for (genvar i = 0; i < 3; i++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_in[i]),
            .deb   (deb[i])
        );
    end

    assign braked = deb[2];

    logic up_ev, dn_ev;
    assign up_ev = deb[0] & ~deb_q[0];
    assign dn_ev = deb[1] & ~deb_q[1];

    assist_state_t      state, state_nx;
    logic [LEVEL_W-1:0] psw_nx, tgt_nx, psw_inc, psw_dec;
    logic [TW-1:0]      tmr, tmr_nx;

    assign psw_inc = psw + 1'b1;
    assign psw_dec = psw - 1'b1;

    always_comb begin
        state_nx = state;
        psw_nx   = psw;
        tgt_nx   = target;
        tmr_nx   = tmr;

        // Simultaneous up and down edges cancel out.
        if (up_ev && !dn_ev && target != MAXL)
            tgt_nx = target + 1'b1;
        else if (dn_ev && !up_ev && target != '0)
            tgt_nx = target - 1'b1;

        if (deb[2]) begin
            state_nx = BRAKE;
            psw_nx   = '0;
            tgt_nx   = '0;
            tmr_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    tmr_nx = '0;
                    if (target > psw)      state_nx = RAMP_UP;
                    else if (target < psw) state_nx = RAMP_DN;
                end
                RAMP_UP: begin
                    if (target == psw) begin
                        state_nx = IDLE;
                        tmr_nx   = '0;
                    end else if (target < psw) begin
                        state_nx = RAMP_DN;
                        tmr_nx   = '0;
                    end else if (tmr == TMR_LAST) begin
                        psw_nx = psw_inc;
                        tmr_nx = '0;
                        if (psw_inc == target) state_nx = IDLE;
                    end else begin
                        tmr_nx = tmr + TW'(1);
                    end
                end
                RAMP_DN: begin
                    if (target == psw) begin
                        state_nx = IDLE;
                        tmr_nx   = '0;
                    end else if (target > psw) begin
                        state_nx = RAMP_UP;
                        tmr_nx   = '0;
                    end else if (tmr == TMR_LAST) begin
                        psw_nx = psw_dec;
                        tmr_nx = '0;
                        if (psw_dec == target) state_nx = IDLE;
                    end else begin
                        tmr_nx = tmr + TW'(1);
                    end
                end
                default: begin
                    // Brake released: settle at zero, no resume of the old level.
                    state_nx = IDLE;
                    psw_nx   = '0;
                    tgt_nx   = '0;
                    tmr_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            psw     <= '0;
            target  <= '0;
            tmr     <= '0;
            deb_q   <= '0;
            ramping <= 1'b0;
        end else begin
            state   <= state_nx;
            psw     <= psw_nx;
            target  <= tgt_nx;
            tmr     <= tmr_nx;
            deb_q   <= deb;
            ramping <= (state_nx == RAMP_UP) || (state_nx == RAMP_DN);
        end
    end
endmodule

// File: tb/tb_assist_level_ctrl.sv
// Directed bench for assist_level_ctrl with short debounce and ramp intervals.
module tb_assist_level_ctrl;
    localparam int MAXL = 7;

    logic       clk = 1'b0;
    logic       rst_n, btn_up, btn_down, brake;
    logic [2:0] psw, target;
    logic       ramping, braked;

    int n_chk  = 0;
    int n_fail = 0;
    int model_tgt = 0;
    int exp_q[$];

    assist_level_ctrl #(.LEVEL_W(3), .DEB_CYCLES(4), .RAMP_CYCLES(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .brake    (brake),
        .psw      (psw),
        .target   (target),
        .ramping  (ramping),
        .braked   (braked)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One press of 5 clocks starting right after an edge; the bench model predicts
    // target at +7, ramp entry at +8 and a single psw step at +16.
    task automatic press_step(input bit up, input bit dn, input string tag);
        int old, nt, e;
        old = model_tgt;
        nt  = old;
        if (up && !dn && old < MAXL)      nt = old + 1;
        else if (dn && !up && old > 0)    nt = old - 1;
        if (nt != old) exp_q.push_back(nt);
        btn_up   = up;
        btn_down = dn;
        tick(5);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(1);
        check($sformatf("%s_tgt_pre", tag), target, old);
        tick(1);
        check($sformatf("%s_tgt", tag), target, nt);
        model_tgt = nt;
        if (nt != old) begin
            tick(1);
            check($sformatf("%s_ramp_on", tag), ramping, 1);
            tick(7);
            check($sformatf("%s_psw_hold", tag), psw, old);
            check($sformatf("%s_ramp_hold", tag), ramping, 1);
            tick(1);
            e = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
            check($sformatf("%s_psw_step", tag), psw, e);
            check($sformatf("%s_ramp_off", tag), ramping, 0);
        end else begin
            tick(9);
            check($sformatf("%s_psw_same", tag), psw, old);
            check($sformatf("%s_ramp_idle", tag), ramping, 0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        brake    = 1'b0;
        tick(3);
        check("rst_psw", psw, 0);
        check("rst_target", target, 0);
        check("rst_ramping", ramping, 0);
        check("rst_braked", braked, 0);
        rst_n = 1'b1;
        tick(2);

        // Single press, then two more: psw walks 1, 2, 3.
        press_step(1, 0, "up1");
        press_step(1, 0, "up2");
        press_step(1, 0, "up3");
        check("three_up_target", target, 3);

        // Asynchronous reset in the middle of a ramp from 3 toward 4.
        btn_up = 1'b1;
        tick(5);
        btn_up = 1'b0;
        tick(5);
        check("mid_ramp_on", ramping, 1);
        check("mid_ramp_psw", psw, 3);
        check("mid_ramp_tgt", target, 4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_psw", psw, 0);
        check("async_rst_tgt", target, 0);
        check("async_rst_ramp", ramping, 0);
        model_tgt = 0;
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Bounce shorter than the debounce window never registers.
        btn_up = 1'b1;
        tick(2);
        btn_up = 1'b0;
        tick(1);
        btn_up = 1'b1;
        tick(3);
        btn_up = 1'b0;
        tick(12);
        check("bounce_tgt", target, 0);
        check("bounce_psw", psw, 0);
        check("bounce_ramp", ramping, 0);

        // Saturation at both ends, then simultaneous presses.
        for (int i = 0; i < 9; i++) press_step(1, 0, $sformatf("sat_up%0d", i));
        check("sat_top_tgt", target, 7);
        check("sat_top_psw", psw, 7);
        for (int i = 0; i < 9; i++) press_step(0, 1, $sformatf("sat_dn%0d", i));
        check("sat_bot_tgt", target, 0);
        check("sat_bot_psw", psw, 0);
        press_step(1, 1, "both0");
        press_step(1, 0, "pre_both");
        press_step(1, 1, "both1");

        // Climb to 4, start toward 5 and brake before the step lands.
        for (int i = 0; i < 3; i++) press_step(1, 0, $sformatf("to4_%0d", i));
        check("pre_brake_psw", psw, 4);
        btn_up = 1'b1;
        tick(5);
        btn_up = 1'b0;
        tick(3);
        check("brk_ramp_on", ramping, 1);
        brake = 1'b1;
        tick(6);
        check("brk_braked", braked, 1);
        check("brk_psw_pre", psw, 4);
        tick(1);
        check("brk_psw", psw, 0);
        check("brk_tgt", target, 0);
        check("brk_ramp", ramping, 0);
        model_tgt = 0;
        exp_q.delete();

        btn_up = 1'b1;
        tick(5);
        btn_up = 1'b0;
        tick(11);
        check("brk_up_tgt", target, 0);
        check("brk_up_psw", psw, 0);
        check("brk_still", braked, 1);

        brake = 1'b0;
        tick(6);
        check("rel_braked", braked, 0);
        tick(2);
        check("rel_psw", psw, 0);
        check("rel_tgt", target, 0);
        check("rel_ramp", ramping, 0);
        press_step(1, 0, "after_brake");
        check("after_brake_psw", psw, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
